instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Inverse of the team's immediate generator. Takes an instruction type code, register/funct fields, opcode and a 64-bit signed immediate, range-checks the immediate, and packs it into a 32-bit RV64 instruction word. Legal words are tagged with a running byte address and buffered in a small FIFO for the instruction-memory loader and test-program builder. Illegal requests are dropped and counted.

Parameters:
DEPTH, 4, output FIFO entries; power of 2, at least 2.
ADDR_W, 32, width of the address counter and out_addr.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_type  in  4  immediate format: 1 I (ADDI), 2 B (BEQ/BNE), 3 U (LUI), 4 S (SD), 5 J (JAL); other codes are illegal
in_opcode  in  7  placed at bits [6:0]
in_funct3  in  3  placed at [14:12] for I/B/S; ignored for U/J
in_rd  in  5  placed at [11:7] for I/U/J
in_rs1  in  5  placed at [19:15] for I/B/S
in_rs2  in  5  placed at [24:20] for B/S
in_imm  in  64  signed immediate, in the same scaling the immediate generator produces
addr_load  in  1  load the address counter
addr_value  in  ADDR_W  value for addr_load
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer pops when out_valid && out_ready
out_instr  out  32  encoded word at the FIFO head
out_addr  out  ADDR_W  byte address of out_instr
err_valid  out  1  one-cycle pulse: an accepted request was rejected
err_count  out  8  saturating count of rejected requests

Behaviour:
- Reset (synchronous, same edge): FIFO emptied; out_valid=0; out_instr=0; out_addr=0; address counter=0; err_valid=0; err_count=0. Reset mid-operation discards all buffered entries.
- in_ready = !full && !addr_load.
  - addr_load has priority: the counter takes addr_value at the edge and no request is accepted that cycle.
- Legality and field packing (f is the field value):
  - I: in_imm in [-2048, 2047]; f=imm[11:0] goes to [31:20].
  - S: same range; imm[11:5] goes to [31:25], imm[4:0] goes to [11:7].
  - B: imm[1:0] must be 00; f=imm>>>2 must lie in [-2048, 2047], so imm is in [-8192, 8188]. Packing: [31]=f[11], [7]=f[10], [30:25]=f[9:4], [11:8]=f[3:0].
  - U: imm[11:0] must be 0; imm[63:31] must all be equal; [31:12]=imm[31:12].
  - J: imm[1:0] must be 00; f=imm>>>2 must lie in [-2^19, 2^19-1]. Packing: [31]=f[19], [19:12]=f[18:11], [20]=f[10], [30:21]=f[9:0].
  - Fields not listed for a type are 0.
- Accepted legal request: the encoded word and the current counter value are written to the FIFO at that edge. The counter advances by 4 and wraps modulo 2^ADDR_W.
- Accepted illegal request (bad type, range or alignment): nothing is written and the counter is unchanged. err_valid=1 for the next cycle only; err_count increments and saturates at 255.
- Latency: a request accepted at edge N appears on out_* after edge N when the FIFO was empty, i.e. out_valid is high in cycle N+1. Order is strictly FIFO.
- Simultaneous push and pop: the occupancy count is unchanged. No push can occur when full because in_ready=0 then. A pop from empty is impossible because out_valid=0.
- out_instr and out_addr are held stable while out_valid && !out_ready.

Test Plan:
- Reset, then I type, opcode 0x13, funct3 0, rd 1, rs1 0, imm 5 -> out_instr=0x00500093, out_addr=0x0 one cycle later. Repeat with imm -1 -> 0xFFF00093, addr 0x4.
- U type, opcode 0x37, rd 5, imm 0x12345000 -> 0x123452B7. Same with imm 0x12345001 -> no output, err_valid pulse, err_count=1.
- J type, opcode 0x6F, rd 1, imm 8 -> 0x004000EF. B type with imm 6 -> rejected. I type with imm 2048 -> rejected; err_count=2 and then 3.
- Hold out_ready=0 and push 4 legal requests -> in_ready drops after the 4th. Addresses are 0,4,8,12; draining returns them in order. Push+pop in the same cycle keeps in_ready high.
- addr_load with 0x100 while in_valid=1 -> in_ready=0 that cycle; the next accepted request gets out_addr=0x100. Load 0xFFFFFFFC, push two -> addresses 0xFFFFFFFC then 0x0.
- Assert reset with 3 entries buffered -> next cycle out_valid=0 and err_count=0. The next push gets addr 0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: range-checks an immediate, packs it into a 32-bit RV64 word,
// tags legal words with a running byte address and queues them in a FIFO.
module instr_encoder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_type,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [63:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_valid,
  output logic [7:0]        err_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [3:0] TYPE_I = 4'd1;
  localparam logic [3:0] TYPE_B = 4'd2;
  localparam logic [3:0] TYPE_U = 4'd3;
  localparam logic [3:0] TYPE_S = 4'd4;
  localparam logic [3:0] TYPE_J = 4'd5;

  logic [31:0]       instr_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_valid_q, err_valid_d;
  logic [7:0]        err_count_q, err_count_d;

  logic [31:0] word_c;
  logic        legal_c;
  logic        full_c, accept_c, push_c, pop_c;
  logic [11:0] fb_c;
  logic [19:0] fj_c;
  logic        fits_s12_c, fits_b_c, fits_j_c, fits_u_c, aligned_c, u_low_zero_c;

  // Scaled branch/jump fields and sign-extension range tests
  assign fb_c         = in_imm[13:2];
  assign fj_c         = in_imm[21:2];
  assign fits_s12_c   = (&in_imm[63:11]) | ~(|in_imm[63:11]);
  assign fits_b_c     = (&in_imm[63:13]) | ~(|in_imm[63:13]);
  assign fits_j_c     = (&in_imm[63:21]) | ~(|in_imm[63:21]);
  assign fits_u_c     = (&in_imm[63:31]) | ~(|in_imm[63:31]);
  assign aligned_c    = (in_imm[1:0] == 2'b00);
  assign u_low_zero_c = (in_imm[11:0] == 12'd0);

  // Per-format legality and field packing
  always_comb begin
    word_c  = '0;
    legal_c = 1'b0;
    case (in_type)
      TYPE_I: begin
        legal_c = fits_s12_c;
        word_c  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      TYPE_S: begin
        legal_c = fits_s12_c;
        word_c  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      TYPE_B: begin
        legal_c = aligned_c && fits_b_c;
        word_c  = {fb_c[11], fb_c[9:4], in_rs2, in_rs1, in_funct3, fb_c[3:0], fb_c[10], in_opcode};
      end
      TYPE_U: begin
        legal_c = u_low_zero_c && fits_u_c;
        word_c  = {in_imm[31:12], in_rd, in_opcode};
      end
      TYPE_J: begin
        legal_c = aligned_c && fits_j_c;
        word_c  = {fj_c[19], fj_c[9:0], fj_c[10], fj_c[18:11], in_rd, in_opcode};
      end
      default: begin
        legal_c = 1'b0;
        word_c  = '0;
      end
    endcase
  end

  assign full_c    = (count_q == CNT_W'(DEPTH));
  assign in_ready  = !full_c && !addr_load;
  assign accept_c  = in_valid && in_ready;
  assign push_c    = accept_c && legal_c;
  assign out_valid = (count_q != '0);
  assign pop_c     = out_valid && out_ready;
  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign out_addr  = out_valid ? addr_mem_q[rd_ptr_q]  : '0;
  assign err_valid = err_valid_q;
  assign err_count = err_count_q;

  // Next-state for FIFO pointers, address counter and error tracking
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    addr_d      = addr_q;
    err_valid_d = 1'b0;
    err_count_d = err_count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (addr_load)   addr_d = addr_value;
    else if (push_c) addr_d = addr_q + ADDR_W'(4);
    if (accept_c && !legal_c) begin
      err_valid_d = 1'b1;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      err_valid_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      err_valid_q <= err_valid_d;
      err_count_q <= err_count_d;
    end
  end

  // FIFO storage; contents are don't-care until counted valid
  always_ff @(posedge clk) begin
    if (push_c) begin
      instr_mem_q[wr_ptr_q] <= word_c;
      addr_mem_q[wr_ptr_q]  <= addr_q;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: fixed vector table, directed FIFO/address
// sequences and randomized traffic checked against a queue-based model.
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_type;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [63:0] in_imm;
  logic        addr_load;
  logic [31:0] addr_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_valid;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .addr_load(addr_load), .addr_value(addr_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_valid(err_valid), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [31:0] a;
  } ent_t;

  typedef struct {
    logic [3:0]  typ;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    bit          legal;
    logic [31:0] word;
  } vec_t;

  // Reference model state
  ent_t        mq[$];
  logic [31:0] m_addr;
  bit          m_errv;
  int          m_errc;
  bit          m_rst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding computed from the format rules with plain arithmetic
  function automatic void model_enc(input logic [3:0] t, input logic [6:0] op,
                                    input logic [2:0] f3, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input longint imm, output bit legal,
                                    output logic [31:0] w);
    longint r, f;
    longint op_l, f3_l, rd_l, rs1_l, rs2_l;
    op_l = longint'(op); f3_l = longint'(f3); rd_l = longint'(rd);
    rs1_l = longint'(rs1); rs2_l = longint'(rs2);
    r = 0;
    legal = 1'b0;
    case (t)
      4'd1: begin
        legal = (imm >= -2048) && (imm <= 2047);
        r = ((imm & 'hfff) << 20) | (rs1_l << 15) | (f3_l << 12) | (rd_l << 7) | op_l;
      end
      4'd4: begin
        legal = (imm >= -2048) && (imm <= 2047);
        r = (((imm >> 5) & 'h7f) << 25) | (rs2_l << 20) | (rs1_l << 15) | (f3_l << 12)
          | ((imm & 'h1f) << 7) | op_l;
      end
      4'd2: begin
        legal = ((imm & 3) == 0) && (imm >= -8192) && (imm <= 8188);
        f = imm / 4;
        r = (((f >> 11) & 1) << 31) | (((f >> 4) & 'h3f) << 25) | (rs2_l << 20)
          | (rs1_l << 15) | (f3_l << 12) | ((f & 'hf) << 8) | (((f >> 10) & 1) << 7) | op_l;
      end
      4'd3: begin
        legal = ((imm & 'hfff) == 0) && (imm >= -(longint'(1) << 31))
             && (imm <= (longint'(1) << 31) - 1);
        r = (imm & 'hfffff000) | (rd_l << 7) | op_l;
      end
      4'd5: begin
        f = imm / 4;
        legal = ((imm & 3) == 0) && (f >= -(longint'(1) << 19)) && (f <= (longint'(1) << 19) - 1);
        r = (((f >> 19) & 1) << 31) | ((f & 'h3ff) << 21) | (((f >> 10) & 1) << 20)
          | (((f >> 11) & 'hff) << 12) | (rd_l << 7) | op_l;
      end
      default: legal = 1'b0;
    endcase
    w = r[31:0];
  endfunction

  // One clock: check in_ready, advance the model at the edge, check outputs
  task automatic cycle();
    bit exp_rdy, acc, lg, pop;
    logic [31:0] w;
    ent_t e;
    #1;
    exp_rdy = (mq.size() < DEPTH) && !addr_load;
    chk("in_ready", in_ready, exp_rdy);
    model_enc(in_type, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm, lg, w);
    acc = in_valid && exp_rdy;
    pop = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_addr = 0; m_errv = 0; m_errc = 0; m_rst = 1;
    end else begin
      m_rst = 0;
      if (pop) e = mq.pop_front();
      m_errv = acc && !lg;
      if (acc && !lg && m_errc != 255) m_errc++;
      if (addr_load) m_addr = addr_value;
      else if (acc && lg) begin
        e.w = w; e.a = m_addr;
        mq.push_back(e);
        m_addr = m_addr + 32'd4;
      end
    end
    @(negedge clk);
    chk("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("out_instr", out_instr, mq[0].w);
      chk("out_addr", out_addr, mq[0].a);
    end
    if (m_rst) begin
      chk("rst_instr", out_instr, 0);
      chk("rst_addr", out_addr, 0);
    end
    chk("err_valid", err_valid, m_errv);
    chk("err_count", err_count, m_errc);
  endtask

  task automatic set_req(input logic [3:0] t, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [63:0] imm);
    in_type = t; in_opcode = op; in_funct3 = f3;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  function automatic vec_t mk(input logic [3:0] t, input logic [6:0] op, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [63:0] imm, input bit legal, input logic [31:0] word);
    vec_t v;
    v.typ = t; v.op = op; v.f3 = f3; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.legal = legal; v.word = word;
    return v;
  endfunction

  vec_t vecs[18];

  initial begin
    longint imm_r;
    vecs[0]  = mk(4'd1, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd5, 1'b1, 32'h00500093);
    vecs[1]  = mk(4'd1, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, -64'sd1, 1'b1, 32'hFFF00093);
    vecs[2]  = mk(4'd3, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0, 64'h12345000, 1'b1, 32'h123452B7);
    vecs[3]  = mk(4'd3, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0, 64'h12345001, 1'b0, 32'h0);
    vecs[4]  = mk(4'd5, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 64'd8, 1'b1, 32'h004000EF);
    vecs[5]  = mk(4'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 64'd6, 1'b0, 32'h0);
    vecs[6]  = mk(4'd1, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd2048, 1'b0, 32'h0);
    vecs[7]  = mk(4'd4, 7'h23, 3'd3, 5'd0, 5'd2, 5'd1, 64'd8, 1'b1, 32'h00113423);
    vecs[8]  = mk(4'd2, 7'h63, 3'd1, 5'd0, 5'd1, 5'd2, 64'd8, 1'b1, 32'h00209263);
    vecs[9]  = mk(4'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, -64'sd8192, 1'b1, 32'h80000063);
    vecs[10] = mk(4'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 64'd8192, 1'b0, 32'h0);
    vecs[11] = mk(4'd5, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, -64'sd4, 1'b1, 32'hFFFFF06F);
    vecs[12] = mk(4'd5, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 64'h200000, 1'b0, 32'h0);
    vecs[13] = mk(4'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd0, 1'b0, 32'h0);
    vecs[14] = mk(4'd6, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd0, 1'b0, 32'h0);
    vecs[15] = mk(4'd3, 7'h37, 3'd0, 5'd0, 5'd0, 5'd0, 64'hFFFFFFFF80000000, 1'b1, 32'h80000037);
    vecs[16] = mk(4'd3, 7'h37, 3'd0, 5'd0, 5'd0, 5'd0, 64'h80000000, 1'b0, 32'h0);
    vecs[17] = mk(4'd1, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, -64'sd2048, 1'b1, 32'h80000013);

    reset = 1'b1; in_valid = 1'b0; addr_load = 1'b0; addr_value = '0; out_ready = 1'b1;
    set_req(4'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0);
    m_addr = 0; m_errv = 0; m_errc = 0; m_rst = 0;
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_err_count", err_count, 8'd0);

    // Fixed-vector table, one request at a time into an empty FIFO
    foreach (vecs[i]) begin
      set_req(vecs[i].typ, vecs[i].op, vecs[i].f3, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      if (vecs[i].legal) begin
        chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
        chk($sformatf("vec%0d_word", i), out_instr, vecs[i].word);
      end else begin
        chk($sformatf("vec%0d_err", i), err_valid, 1'b1);
        chk($sformatf("vec%0d_novalid", i), out_valid, 1'b0);
      end
      cycle();
    end

    // Fill FIFO with consumer stalled, then push+pop at occupancy 3
    reset = 1'b1; cycle(); reset = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      set_req(4'd1, 7'h13, 3'd0, 5'd2, 5'd3, 5'd0, 64'(k + 10));
      cycle();
    end
    chk("full_ready_low", in_ready, 1'b0);
    chk("full_head_addr", out_addr, 32'h0);
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("pushpop_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    repeat (DEPTH + 1) cycle();

    // Address load blocks acceptance, then wraparound
    in_valid = 1'b1; addr_load = 1'b1; addr_value = 32'h100;
    set_req(4'd1, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd1);
    cycle();
    addr_load = 1'b0;
    cycle();
    in_valid = 1'b0;
    chk("load_addr", out_addr, 32'h100);
    addr_load = 1'b1; addr_value = 32'hFFFF_FFFC;
    cycle();
    addr_load = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    cycle();
    in_valid = 1'b0;
    chk("wrap_first", out_addr, 32'hFFFF_FFFC);
    out_ready = 1'b1;
    cycle();
    chk("wrap_second", out_addr, 32'h0);
    cycle();

    // Reset with three entries buffered
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (3) cycle();
    in_valid = 1'b0; reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_errc", err_count, 8'd0);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("midrst_addr", out_addr, 32'h0);
    out_ready = 1'b1;
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 700; n++) begin
      case ($urandom_range(0, 5))
        0: imm_r = longint'($urandom_range(0, 32767)) - 16384;
        1: imm_r = longint'($urandom_range(0, 4194304)) - 2097152;
        2: begin
          imm_r = longint'(int'($urandom() & 32'hFFFF_F000));
          if ($urandom_range(0, 3) == 0) imm_r = imm_r ^ 64'h1_0000_0000;
        end
        3: imm_r = {$urandom(), $urandom()};
        4: case ($urandom_range(0, 5))
             0: imm_r = 2047;  1: imm_r = -2048; 2: imm_r = 8188;
             3: imm_r = -8192; 4: imm_r = 1048572; default: imm_r = -1048576;
           endcase
        default: imm_r = 4 * (longint'($urandom_range(0, 64)) - 32);
      endcase
      set_req(4'($urandom_range(0, 7)), 7'($urandom()), 3'($urandom()), 5'($urandom()),
              5'($urandom()), 5'($urandom()), imm_r);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      addr_load  = ($urandom_range(0, 19) == 0);
      addr_value = $urandom();
      reset      = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0; in_valid = 1'b0; addr_load = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 1) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
